register_file_sb: RTL
=====================

# register_file_sb

Parametrised successor to the core's integer register file for the kianv multicycle RV32IMA datapath. Adds:
- a configurable number of read ports;
- optional synchronous (BRAM-friendly) reads with write-first forwarding;
- an optional combinational write bypass;
- a self-clearing reset sequence that loads the stack pointer;
- a per-register pending-write scoreboard for multicycle producers (loads, MUL/DIV, AMO).

It replaces the plain register file inside the datapath. The control FSM consumes the `busy_*` and `init_done` outputs.

## Interface

Parameters:
- `REGISTER_DEPTH`, 32: number of registers; power of two, ≥ 4.
- `REGISTER_WIDTH`, 32: data width.
- `NUM_READ`, 2: read ports, 1–4.
- `READ_LATENCY`, 0: 0 = combinational read; 1 = registered read.
- `BYPASS`, 1: latency-0 only; a same-cycle write is forwarded to the read data.
- `STACKADDR`, 32'hffff_ffff: value loaded into x2 during the reset sequence.

Ports (AW = $clog2(REGISTER_DEPTH)):
- `clk` in 1: sole clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `init_done` out 1: high once the clear sequence has completed.
- `we` in 1: write enable.
- `A3` in AW: write address.
- `wd` in REGISTER_WIDTH: write data.
- `ra` in NUM_READ*AW: packed read addresses; port i is `ra[i*AW +: AW]`.
- `rd` out NUM_READ*REGISTER_WIDTH: packed read data.
- `busy` out NUM_READ: port i's addressed register has a pending write.
- `sb_set` in 1: mark a register pending (issued producer).
- `sb_addr` in AW: register to mark.

## Operation

State machine:
- States: CLEAR and RUN.
- `rst` forces CLEAR with the counter `clr_cnt` set to 0. A reset asserted mid-sequence or mid-run restarts from 0.
- In CLEAR, every cycle writes `bank[clr_cnt]` with STACKADDR if `clr_cnt == 2`, otherwise 0, then increments `clr_cnt`.
- When `clr_cnt == REGISTER_DEPTH-1` has been written, go to RUN.
- While in CLEAR:
  - `init_done` = 0;
  - `we` and `sb_set` are ignored;
  - the scoreboard is held all-zero;
  - `rd` = 0 and `busy` = 0.

Writes (RUN only):
- `we && A3 != 0` writes `bank[A3] <= wd` and clears `sb[A3]`.
- Writes to x0 are discarded.

Scoreboard (RUN only):
- `sb_set && sb_addr != 0` sets `sb[sb_addr]`.
- If the same register is set and written in the same cycle, the set wins: a new producer has been issued, so the bit stays 1.
- `sb[0]` is constantly 0.

Reads, latency 0:
- `rd_i = (ra_i == 0) ? 0 : bank[ra_i]`.
- With BYPASS = 1 and `we && A3 == ra_i != 0`, `rd_i = wd` and `busy_i = 0`.
- Otherwise `busy_i = sb[ra_i]`.

Reads, latency 1:
- `rd_i` and `busy_i` are registered, reflecting `ra_i` sampled at the previous edge.
- Write-first: a write to the same nonzero address in the sampling cycle returns `wd`, and `busy` is 0 unless that same cycle also had `sb_set` to that address.
- BYPASS is ignored.

Width rules: no arithmetic on data. `clr_cnt` is AW+1 bits wide so the terminal compare cannot wrap.

## Timing

- Reset values:
  - `init_done` = 0;
  - `rd` = 0 and `busy` = 0, including the registered outputs at latency 1;
  - state = CLEAR;
  - `clr_cnt` = 0.
- Clear takes exactly REGISTER_DEPTH cycles after `rst` deasserts. `init_done` rises on the edge that completes the write of the last register and stays high until the next `rst`.
- A write is visible to a non-bypassed latency-0 read on the cycle after `we`.
- Scoreboard set/clear is visible on `busy` on the cycle after the request. The only exception is the same-cycle clear via BYPASS/forwarding described above.

## Structure

- Shared package `kianv_regfile_pkg`:
  - `localparam` constants for ZERO_REG = 0 and SP_REG = 2;
  - the state encoding `typedef enum {RF_CLEAR, RF_RUN}`.
- One sub-module, `regfile_scoreboard`:
  - REGISTER_DEPTH-bit vector with set/clear ports and the set-wins priority;
  - NUM_READ lookup outputs;
  - synchronous clear.
- Storage stays a single `reg` array; one write port allows distributed-RAM or BRAM inference.

## Test plan

- **Clear sequence:** assert `rst` for 3 cycles, release → `init_done` rises exactly 32 cycles later. Reading x2 returns 32'hffff_ffff; x1 and x31 return 0. `we` pulses issued during the sequence have no effect.
- **Basic write/read, latency 0, BYPASS = 0:** write x5 = 32'hdeadbeef → same-cycle read of x5 returns the old value 0, next cycle returns 32'hdeadbeef. Write x0 = 32'h1234 → x0 still reads 0.
- **Bypass and write-first:**
  - latency 0, BYPASS = 1: write x7 = 32'hcafe with `ra0 = 7` → `rd0 = 32'hcafe` in the same cycle;
  - latency 1: same stimulus → `rd0 = 32'hcafe` one cycle later.
- **Scoreboard:**
  - `sb_set` x10 → `busy` for x10 is 1 from the next cycle onward;
  - `we` on x10 → `busy` for x10 returns to 0;
  - `sb_set` and `we` on x10 in the same cycle → `busy` stays 1;
  - `sb_set` x0 → `busy` stays 0.
- **Reset mid-run:** with x3 = 32'h55 and `sb[3]` = 1, pulse `rst` → `init_done` = 0 for 32 cycles. Afterwards x3 = 0, `busy` = 0, and x2 = STACKADDR.
- **NUM_READ = 4:** 4 ports read x1, x2, x3, x0 after writes of 1, 2, 3 → values 1, 2, 3, 0, each on its correct packed slice.

Source files
------------

// File: rtl/register_file_sb_pkg.sv
// Shared constants and state encoding for the kianv register file with scoreboard.
package kianv_regfile_pkg;

    localparam int unsigned ZERO_REG = 0;
    localparam int unsigned SP_REG   = 2;

    typedef enum logic {
        RF_CLEAR,
        RF_RUN
    } rf_state_e;

endpackage

// File: rtl/register_file_sb_if.sv
// Register-file bus: write port, packed read ports, scoreboard set and status.
interface register_file_sb_if #(
    parameter int unsigned AW       = 5,
    parameter int unsigned W        = 32,
    parameter int unsigned NUM_READ = 2
);
    logic                   init_done;
    logic                   we;
    logic [AW-1:0]          A3;
    logic [W-1:0]           wd;
    logic [NUM_READ*AW-1:0] ra;
    logic [NUM_READ*W-1:0]  rd;
    logic [NUM_READ-1:0]    busy;
    logic                   sb_set;
    logic [AW-1:0]          sb_addr;

    modport master (
        output we, A3, wd, ra, sb_set, sb_addr,
        input  init_done, rd, busy
    );

    modport slave (
        input  we, A3, wd, ra, sb_set, sb_addr,
        output init_done, rd, busy
    );
endinterface

// File: rtl/register_file_sb_scoreboard.sv
// Pending-write bit per register; a set in the same cycle as a write-clear wins.
module regfile_scoreboard #(
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned NUM_READ  = 2,
    parameter bit          LOOK_NEXT = 1'b0,
    parameter int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   clr_i,
    input  logic                   set_i,
    input  logic [AW-1:0]          set_addr_i,
    input  logic                   wclr_i,
    input  logic [AW-1:0]          wclr_addr_i,
    input  logic [NUM_READ*AW-1:0] look_addr_i,
    output logic [NUM_READ-1:0]    look_o
);
    logic [DEPTH-1:0] sb_q, sb_d, sb_view;

    always_comb begin
        sb_d = sb_q;
        if (wclr_i) sb_d[wclr_addr_i] = 1'b0;
        if (set_i)  sb_d[set_addr_i]  = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (clr_i) sb_q <= '0;
        else       sb_q <= sb_d;
    end

    // Registered readers want the post-edge view so they see write-first behaviour.
    assign sb_view = LOOK_NEXT ? (clr_i ? '0 : sb_d) : sb_q;

    for (genvar i = 0; i < NUM_READ; i++) begin : g_look
        assign look_o[i] = sb_view[look_addr_i[i*AW +: AW]];
    end
endmodule

// File: rtl/register_file_sb.sv
// Integer register file with clear-on-reset sequence, N read ports and pending-write scoreboard.
//   state    | meaning
//   RF_CLEAR | walking clr_cnt over the bank, x2 <= STACKADDR; bus ignored, outputs 0
//   RF_RUN   | normal reads/writes and scoreboard updates
module register_file_sb
    import kianv_regfile_pkg::*;
#(
    parameter int unsigned                 REGISTER_DEPTH = 32,
    parameter int unsigned                 REGISTER_WIDTH = 32,
    parameter int unsigned                 NUM_READ       = 2,
    parameter int unsigned                 READ_LATENCY   = 0,
    parameter bit                          BYPASS         = 1'b1,
    parameter logic [REGISTER_WIDTH-1:0]   STACKADDR      = 32'hffff_ffff
) (
    input logic clk,
    input logic rst,
    register_file_sb_if.slave rf
);
    localparam int unsigned AW = $clog2(REGISTER_DEPTH);

    rf_state_e                 state_q;
    logic [AW:0]               clr_cnt_q;
    logic [REGISTER_WIDTH-1:0] bank [REGISTER_DEPTH];

    logic                      running, clr_last, wr_run, set_run;
    logic                      bank_we;
    logic [AW-1:0]             bank_wa;
    logic [REGISTER_WIDTH-1:0] bank_wd;
    logic [NUM_READ-1:0]       sb_look;

    assign running  = (state_q == RF_RUN);
    assign clr_last = (state_q == RF_CLEAR) && (clr_cnt_q == (AW+1)'(REGISTER_DEPTH-1));
    assign wr_run   = running && rf.we && (rf.A3 != AW'(ZERO_REG));
    assign set_run  = running && rf.sb_set;
    assign rf.init_done = running;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RF_CLEAR;
            clr_cnt_q <= '0;
        end else if (state_q == RF_CLEAR) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (clr_last) state_q <= RF_RUN;
        end
    end

    // Clear sequence and bus writes share the single bank write port.
    always_comb begin
        bank_we = 1'b0;
        bank_wa = rf.A3;
        bank_wd = rf.wd;
        if (!rst) begin
            if (!running) begin
                bank_we = 1'b1;
                bank_wa = clr_cnt_q[AW-1:0];
                bank_wd = (clr_cnt_q == (AW+1)'(SP_REG)) ? STACKADDR : '0;
            end else begin
                bank_we = wr_run;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bank_we) bank[bank_wa] <= bank_wd;
    end

    regfile_scoreboard #(
        .DEPTH     (REGISTER_DEPTH),
        .NUM_READ  (NUM_READ),
        .LOOK_NEXT (READ_LATENCY != 0),
        .AW        (AW)
    ) u_sb (
        .clk         (clk),
        .clr_i       (rst || !running),
        .set_i       (set_run),
        .set_addr_i  (rf.sb_addr),
        .wclr_i      (wr_run),
        .wclr_addr_i (rf.A3),
        .look_addr_i (rf.ra),
        .look_o      (sb_look)
    );

    for (genvar i = 0; i < NUM_READ; i++) begin : g_port
        logic [AW-1:0] ra_sel;
        assign ra_sel = rf.ra[i*AW +: AW];

        if (READ_LATENCY == 0) begin : g_comb
            logic fwd;
            assign fwd = BYPASS && wr_run && (rf.A3 == ra_sel);
            assign rf.rd[i*REGISTER_WIDTH +: REGISTER_WIDTH] =
                (!running || ra_sel == '0) ? '0 : (fwd ? rf.wd : bank[ra_sel]);
            assign rf.busy[i] = running && !fwd && sb_look[i];
        end else begin : g_reg
            logic [REGISTER_WIDTH-1:0] rd_d, rd_q;
            logic                      busy_d, busy_q;

            // Capture the post-edge contents, forwarding whatever the write port stores now.
            always_comb begin
                rd_d   = '0;
                busy_d = 1'b0;
                if ((running || clr_last) && ra_sel != '0) begin
                    rd_d   = (bank_we && bank_wa == ra_sel) ? bank_wd : bank[ra_sel];
                    busy_d = sb_look[i];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_q   <= '0;
                    busy_q <= 1'b0;
                end else begin
                    rd_q   <= rd_d;
                    busy_q <= busy_d;
                end
            end

            assign rf.rd[i*REGISTER_WIDTH +: REGISTER_WIDTH] = rd_q;
            assign rf.busy[i] = busy_q;
        end
    end
endmodule
